poly_eval_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one polynomial-evaluation datapath between
//  N_REQ requesters. Accepts one operand set (A,B,C,X) per transaction, drives the datapath

---
 rtl/poly_eval_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_poly_eval_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_arbiter.sv
// ---------------------------------------------------------------------------
// poly_eval_arbiter
//
// Round-robin arbiter and sequencer that shares one 8-bit polynomial
// datapath (Y = A*X*X + B*X + C, mod 256) between N_REQ requesters.
// It accepts one operand set per transaction, loads the operands into the
// datapath, steps the ALU through five compute cycles, and returns the
// datapath result tagged with the requester ID.
//
// Ports
//   clk, resetn              clock (rising edge), async active-low reset
//   req_valid / req_ready    per-requester handshake, ready is one-hot
//   req_a/b/c/x              packed 8-bit operands, requester i at [8i+7:8i]
//   rsp_valid / rsp_ready    result handshake
//   rsp_id, rsp_data         owner of the result and Y mod 256
//   busy                     high whenever a transaction is in flight
//   dp_*                     datapath load strobes, ALU selects and opcode
//   dp_data_result           datapath result register
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a valid requester, grant is combinational
// S_LD_A  | drive captured A into the datapath A register
// S_LD_B  | drive captured B into the datapath B register
// S_LD_C  | drive captured C into the datapath C register
// S_LD_X  | drive captured X into the datapath X register
// S_CY0   | A <= A*X
// S_CY1   | A <= A*X   (now A*X*X)
// S_CY2   | A <= A + C
// S_CY3   | B <= B*X
// S_CY4   | R <= A + B
// S_RESP  | present result until rsp_ready
// ---------------------------------------------------------------------------
module poly_eval_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*8-1:0]   req_a,
    input  logic [N_REQ*8-1:0]   req_b,
    input  logic [N_REQ*8-1:0]   req_c,
    input  logic [N_REQ*8-1:0]   req_x,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_data,
    output logic                 busy,
    output logic [7:0]           dp_data_in,
    output logic                 dp_ld_a,
    output logic                 dp_ld_b,
    output logic                 dp_ld_c,
    output logic                 dp_ld_x,
    output logic                 dp_ld_r,
    output logic                 dp_ld_alu_out,
    output logic [1:0]           dp_alu_select_a,
    output logic [1:0]           dp_alu_select_b,
    output logic                 dp_alu_op,
    input  logic [7:0]           dp_data_result
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD_A = 4'd1,
        S_LD_B = 4'd2,
        S_LD_C = 4'd3,
        S_LD_X = 4'd4,
        S_CY0  = 4'd5,
        S_CY1  = 4'd6,
        S_CY2  = 4'd7,
        S_CY3  = 4'd8,
        S_CY4  = 4'd9,
        S_RESP = 4'd10
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_id;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic [7:0]      r_c;
    logic [7:0]      r_x;

    logic            w_any_valid;
    logic [ID_W-1:0] w_grant_id;
    logic            w_accept;
    logic [ID_W-1:0] w_ptr_nxt;

    // Requester index k positions above base, wrapping at N_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return ID_W'(s);
    endfunction

    // First valid requester scanning upward from the round-robin pointer.
    always_comb begin
        w_any_valid = 1'b0;
        w_grant_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any_valid && req_valid[wrap_idx(r_ptr, k)]) begin
                w_any_valid = 1'b1;
                w_grant_id  = wrap_idx(r_ptr, k);
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_any_valid;
    assign w_ptr_nxt = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;

    // Operand capture and pointer advance; operands are frozen at accept so
    // later changes on the request bus cannot corrupt the transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
            r_id  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_x   <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_nxt;
            r_id  <= w_grant_id;
            r_a   <= req_a[8*w_grant_id +: 8];
            r_b   <= req_b[8*w_grant_id +: 8];
            r_c   <= req_c[8*w_grant_id +: 8];
            r_x   <= req_x[8*w_grant_id +: 8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_LD_A;
            S_LD_A:  w_state_nxt = S_LD_B;
            S_LD_B:  w_state_nxt = S_LD_C;
            S_LD_C:  w_state_nxt = S_LD_X;
            S_LD_X:  w_state_nxt = S_CY0;
            S_CY0:   w_state_nxt = S_CY1;
            S_CY1:   w_state_nxt = S_CY2;
            S_CY2:   w_state_nxt = S_CY3;
            S_CY3:   w_state_nxt = S_CY4;
            S_CY4:   w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready       = '0;
        rsp_valid       = 1'b0;
        rsp_id          = '0;
        rsp_data        = 8'd0;
        busy            = (r_state != S_IDLE);
        dp_data_in      = 8'd0;
        dp_ld_a         = 1'b0;
        dp_ld_b         = 1'b0;
        dp_ld_c         = 1'b0;
        dp_ld_x         = 1'b0;
        dp_ld_r         = 1'b0;
        dp_ld_alu_out   = 1'b0;
        dp_alu_select_a = SEL_A;
        dp_alu_select_b = SEL_A;
        dp_alu_op       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gated by resetn so the grant is not visible while reset is held.
                if (w_any_valid && resetn) req_ready[w_grant_id] = 1'b1;
            end
            S_LD_A: begin
                dp_data_in = r_a;
                dp_ld_a    = 1'b1;
            end
            S_LD_B: begin
                dp_data_in = r_b;
                dp_ld_b    = 1'b1;
            end
            S_LD_C: begin
                dp_data_in = r_c;
                dp_ld_c    = 1'b1;
            end
            S_LD_X: begin
                dp_data_in = r_x;
                dp_ld_x    = 1'b1;
            end
            S_CY0, S_CY1: begin
                dp_ld_alu_out   = 1'b1;
                dp_ld_a         = 1'b1;
                dp_alu_select_a = SEL_A;
                dp_alu_select_b = SEL_X;
                dp_alu_op       = 1'b1;
            end
            S_CY2: begin
                dp_ld_alu_out   = 1'b1;
                dp_ld_a         = 1'b1;
                dp_alu_select_a = SEL_A;
                dp_alu_select_b = SEL_C;
            end
            S_CY3: begin
                dp_ld_alu_out   = 1'b1;
                dp_ld_b         = 1'b1;
                dp_alu_select_a = SEL_B;
                dp_alu_select_b = SEL_X;
                dp_alu_op       = 1'b1;
            end
            S_CY4: begin
                dp_ld_r         = 1'b1;
                dp_alu_select_a = SEL_A;
                dp_alu_select_b = SEL_B;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = r_id;
                rsp_data  = dp_data_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_poly_eval_arbiter.sv
module tb_poly_eval_arbiter;

    logic        clk;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b, req_c, req_x;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [7:0]  dp_data_in;
    logic        dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r, dp_ld_alu_out;
    logic [1:0]  dp_alu_select_a, dp_alu_select_b;
    logic        dp_alu_op;
    logic [7:0]  dp_data_result;

    int n_chk  = 0;
    int n_fail = 0;

    poly_eval_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_x(req_x),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
        .dp_data_in(dp_data_in),
        .dp_ld_a(dp_ld_a), .dp_ld_b(dp_ld_b), .dp_ld_c(dp_ld_c),
        .dp_ld_x(dp_ld_x), .dp_ld_r(dp_ld_r), .dp_ld_alu_out(dp_ld_alu_out),
        .dp_alu_select_a(dp_alu_select_a), .dp_alu_select_b(dp_alu_select_b),
        .dp_alu_op(dp_alu_op), .dp_data_result(dp_data_result)
    );

    // Polynomial datapath shared with the arbiter.
    logic [7:0] m_a, m_b, m_c, m_x, m_r;
    logic [7:0] w_opa, w_opb, w_alu;

    function automatic logic [7:0] pick(input logic [1:0] s, input logic [7:0] a, b, c, x);
        case (s)
            2'd0: return a;
            2'd1: return b;
            2'd2: return c;
            default: return x;
        endcase
    endfunction

    always_comb begin
        w_opa = pick(dp_alu_select_a, m_a, m_b, m_c, m_x);
        w_opb = pick(dp_alu_select_b, m_a, m_b, m_c, m_x);
        w_alu = dp_alu_op ? 8'(w_opa * w_opb) : 8'(w_opa + w_opb);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_a <= '0; m_b <= '0; m_c <= '0; m_x <= '0; m_r <= '0;
        end else begin
            if (dp_ld_a) m_a <= dp_ld_alu_out ? w_alu : dp_data_in;
            if (dp_ld_b) m_b <= dp_ld_alu_out ? w_alu : dp_data_in;
            if (dp_ld_c) m_c <= dp_ld_alu_out ? w_alu : dp_data_in;
            if (dp_ld_x) m_x <= dp_ld_alu_out ? w_alu : dp_data_in;
            if (dp_ld_r) m_r <= w_alu;
        end
    end
    assign dp_data_result = m_r;

    logic [18:0] ctl_vec;
    logic [34:0] all_out;
    assign ctl_vec = {dp_data_in, dp_ld_a, dp_ld_b, dp_ld_c, dp_ld_x, dp_ld_r,
                      dp_ld_alu_out, dp_alu_select_a, dp_alu_select_b, dp_alu_op};
    assign all_out = {req_ready, rsp_valid, rsp_id, rsp_data, busy, ctl_vec};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, b, c, x);
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_c[id*8 +: 8] = c;
        req_x[id*8 +: 8] = x;
    endtask

    // Counts negedges from the accept edge until rsp_valid (bounded).
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_one(input string tag, input logic [3:0] mask, input int gid,
                           input logic [7:0] a, b, c, x, input logic [7:0] exp_y);
        int cyc;
        set_ops(gid, a, b, c, x);
        req_valid = mask;
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_grant"}, req_ready, 64'(1 << gid));
        @(negedge clk);
        req_valid = '0;
        set_ops(gid, 8'hff, 8'hff, 8'hff, 8'hff);
        wait_rsp(cyc);
        chk({tag, "_latency"}, cyc, 10);
        chk({tag, "_id"}, rsp_id, gid);
        chk({tag, "_data"}, rsp_data, exp_y);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_idle"}, {busy, rsp_valid}, 0);
    endtask

    logic [18:0] exp_ctl [1:9];
    int cyc;
    int gid;

    initial begin
        exp_ctl[1] = {8'd1, 6'b100000, 2'd0, 2'd0, 1'b0};
        exp_ctl[2] = {8'd2, 6'b010000, 2'd0, 2'd0, 1'b0};
        exp_ctl[3] = {8'd3, 6'b001000, 2'd0, 2'd0, 1'b0};
        exp_ctl[4] = {8'd4, 6'b000100, 2'd0, 2'd0, 1'b0};
        exp_ctl[5] = {8'd0, 6'b100001, 2'd0, 2'd3, 1'b1};
        exp_ctl[6] = {8'd0, 6'b100001, 2'd0, 2'd3, 1'b1};
        exp_ctl[7] = {8'd0, 6'b100001, 2'd0, 2'd2, 1'b0};
        exp_ctl[8] = {8'd0, 6'b010001, 2'd1, 2'd3, 1'b1};
        exp_ctl[9] = {8'd0, 6'b000010, 2'd0, 2'd1, 1'b0};

        resetn = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_x = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_out, 0);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_no_req", {busy, req_ready}, 0);

        // 1: req0 alone, full control sequence and exact latency
        set_ops(0, 8'd1, 8'd2, 8'd3, 8'd4);
        req_valid = 4'b0001;
        #1;
        chk("t1_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        for (int c = 1; c <= 9; c++) begin
            chk($sformatf("t1_ctl%0d", c), ctl_vec, exp_ctl[c]);
            @(negedge clk);
        end
        chk("t1_rsp", {rsp_valid, rsp_id, rsp_data, busy}, {1'b1, 2'd0, 8'd27, 1'b1});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t1_idle", {busy, rsp_valid, rsp_data}, 0);

        // 2: truncation mod 256
        run_one("t2", 4'b0001, 0, 8'd5, 8'd7, 8'd9, 8'd10, 8'h43);

        // 3: all requesters valid, pointer from reset -> 0,1,2,3,0
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_ops(i, 8'(i + 1), 8'd1, 8'(i), 8'd2);
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            gid = k % 4;
            cyc = 0;
            while (req_ready == 0 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            chk($sformatf("t3_grant%0d", k), req_ready, 64'(1 << gid));
            @(negedge clk);
            wait_rsp(cyc);
            chk($sformatf("t3_latency%0d", k), cyc, 10);
            chk($sformatf("t3_id%0d", k), rsp_id, gid);
            chk($sformatf("t3_data%0d", k), rsp_data, 5 * gid + 6);
            chk($sformatf("t3_noready%0d", k), req_ready, 0);
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);

        // 4: back-pressure on the response (pointer now 1)
        set_ops(1, 8'd2, 8'd3, 8'd4, 8'd5);
        req_valid = 4'b0010;
        #1;
        chk("t4_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(cyc);
        req_valid = 4'hf;
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("t4_hold%0d", s), {rsp_valid, rsp_id, rsp_data, busy, req_ready},
                {1'b1, 2'd1, 8'd69, 1'b1, 4'b0000});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_released", {busy, rsp_valid, rsp_data, req_ready}, {1'b0, 1'b0, 8'd0, 4'b0100});
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);

        // 5: pointer 2 -> grant 0, then req2 alone, then req3 beats req0
        run_one("t5a", 4'b0001, 0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1);
        run_one("t5b", 4'b0100, 2, 8'd0, 8'd0, 8'd7, 8'd3, 8'd7);
        run_one("t5c", 4'b1001, 3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3);

        // 6: reset during S_CY2 aborts the transaction and clears the pointer
        set_ops(1, 8'd1, 8'd2, 8'd3, 8'd4);
        req_valid = 4'b0010;
        #1;
        chk("t6_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        chk("t6_in_cy2", {dp_ld_a, dp_ld_alu_out, dp_alu_select_b, dp_alu_op}, 5'b11100);
        req_valid = 4'hf;
        resetn = 1'b0;
        #1;
        chk("t6_reset_outputs", all_out, 0);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk($sformatf("t6_no_rsp%0d", s), all_out, 0);
        end
        req_valid = '0;
        resetn = 1'b1;
        @(negedge clk);
        run_one("t6_ptr", 4'b0101, 0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        run_one("t6", 4'b0010, 1, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
